// File: rtl/lsu_if.sv
// lsu_if
// Bundles the request/response handshake between the CPU datapath and the
// load/store unit, and the word-wide data-memory bus the unit drives.
//   slave  : view of the load/store unit (takes requests, drives memory)
//   master : view of the environment (issues requests, serves memory reads)
// Signals:
//   req_valid/req_ready       request handshake, accepted when both high at posedge
//   req_write                 1 = store, 0 = load
//   req_size                  00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned              zero-extend loads when 1
//   req_addr/req_wdata        byte address, right-aligned store data
//   resp_valid/rdata/err      one-cycle response pulse with result and error flag
//   mem_addr/wdata/write/read word-aligned memory bus driven by the unit
//   mem_rdata                 read word, valid combinationally while mem_read is high
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of a word-wide, big-endian data memory (byte at offset 0
// lives in [31:24]). Takes one load/store at a time, performs byte/half loads
// with sign or zero extension, and implements sub-word stores as a
// read-modify-write of the containing word. One response per request.
// Parameter:
//   RD_WAIT     extra cycles mem_read is held before mem_rdata is sampled (0..15)
// Optional feature macro:
//   LSU_ERR_EN  when defined, misaligned or size-11 requests skip memory and
//               respond with resp_err=1; when undefined the offending low
//               address bits are cleared and size 11 behaves as a word.
// Ports:
//   clk    in   single clock, all state on posedge
//   rst_n  in   asynchronous active-low reset
//   bus    lsu_if.slave  request/response handshake and memory bus
// All outputs are registered; the FSM computes next-state values in
// always_comb and commits them in a single always_ff.
module load_store_unit #(
    parameter int unsigned RD_WAIT = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;

    logic [1:0]  eff_size;
    logic [31:0] eff_addr;
    logic        bad;

    // Pick the addressed lane out of a big-endian word and extend it.
    // Byte offset k sits 8*(3-k) bits up; half offset 0/2 sits 16/0 bits up.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {~off, 3'b000});
        h = 16'(word >> {~off[1], 4'b0000});
        case (size)
            SZ_BYTE: lane_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: lane_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: lane_extract = word;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a word with store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == SZ_BYTE) begin
            mask = 32'h0000_00FF << {~off, 3'b000};
            data = {24'h0, wd[7:0]} << {~off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {~off[1], 4'b0000};
            data = {16'h0, wd} << {~off[1], 4'b0000};
        end
        lane_merge = (word & ~mask) | data;
    endfunction

`ifdef LSU_ERR_EN
    // Offending requests are flagged and answered without touching memory.
    always_comb begin
        eff_size = bus.req_size;
        eff_addr = bus.req_addr;
        bad      = (bus.req_size == 2'b11) ||
                   (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
    end
`else
    // Offending requests are coerced: size 11 is a word, misaligned low bits cleared.
    always_comb begin
        eff_size = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
        eff_addr = bus.req_addr;
        if (eff_size == SZ_HALF) begin
            eff_addr[0] = 1'b0;
        end else if (eff_size == SZ_WORD) begin
            eff_addr[1:0] = 2'b00;
        end
        bad = 1'b0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                // req_ready_q gates acceptance so nothing is taken in the
                // first cycle after reset release.
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    write_d     = bus.req_write;
                    size_d      = eff_size;
                    uns_d       = bus.req_unsigned;
                    addr_d      = eff_addr;
                    wdata_d     = bus.req_wdata[15:0];
                    cnt_d       = 4'h0;
                    if (bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_write && eff_size == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {eff_addr[31:2], 2'b00};
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = {eff_addr[31:2], 2'b00};
                    end
                end
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    if (write_q) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {addr_q[31:2], 2'b00};
                        mem_wdata_d = lane_merge(bus.mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = lane_extract(bus.mem_rdata, size_q, addr_q[1:0], uns_q);
                        resp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d      = cnt_q + 4'h1;
                    mem_read_d = 1'b1;
                    mem_addr_d = {addr_q[31:2], 2'b00};
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'h0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_read   = mem_read_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives load_store_unit through directed scenarios followed by random
// requests, with a word-array memory attached to the memory bus and an
// arithmetic reference model predicting results, strobe counts and latency.
module tb_load_store_unit;
    localparam int RDW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_if bus();

    load_store_unit #(.RD_WAIT(RDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_fail   = 0;

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'h0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        check({tag, "_resp_err"},   32'(bus.resp_err),   32'h0);
        check({tag, "_mem_read"},   32'(bus.mem_read),   32'h0);
        check({tag, "_mem_write"},  32'(bus.mem_write),  32'h0);
        check({tag, "_resp_rdata"}, bus.resp_rdata,      32'h0);
        check({tag, "_mem_addr"},   bus.mem_addr,        32'h0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,       32'h0);
    endtask

    // Load result: take nbytes starting at byte offset off (big-endian), extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int nbytes,
                                               input int off, input bit uns);
        longint v, m;
        int sh;
        if (nbytes == 4) return word;
        sh = 8 * (4 - off - nbytes);
        m  = (longint'(1) << (8 * nbytes)) - 1;
        v  = (longint'(word) >> sh) & m;
        if (!uns && v >= (m + 1) / 2) v = v - (m + 1);
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                                input int nbytes, input int off);
        longint v, m;
        int sh;
        if (nbytes == 4) return wd;
        sh = 8 * (4 - off - nbytes);
        m  = (longint'(1) << (8 * nbytes)) - 1;
        v  = (longint'(word) & ~(m << sh)) | ((longint'(wd) & m) << sh);
        return 32'(v);
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = 6'(idx);
        pre_data = d;
        ref_mem[idx] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rdata_obs, output logic [31:0] wdata_obs);
        int nb, exp_lat, exp_rd, exp_wr, rd_cnt, wr_cnt, rdy_cnt, lat, k;
        bit err, got;
        logic [31:0] a, old, exp_rdata, exp_wdata;
        err = 1'b0;
        a   = addr;
        case (sz)
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            default: nb = 4;
        endcase
`ifdef LSU_ERR_EN
        err = (sz == 2'd3) || (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`else
        a = a - (a % nb);
`endif
        old       = ref_mem[a[7:2]];
        exp_rdata = 32'h0;
        exp_wdata = 32'h0;
        exp_rd    = 0;
        exp_wr    = 0;
        if (err) begin
            exp_lat = 1;
        end else if (!wr) begin
            exp_rd    = 1 + RDW;
            exp_lat   = 2 + RDW;
            exp_rdata = model_load(old, nb, int'(a[1:0]), uns);
        end else begin
            exp_wr    = 1;
            exp_wdata = model_store(old, wd, nb, int'(a[1:0]));
            exp_rd    = (nb == 4) ? 0 : 1 + RDW;
            exp_lat   = (nb == 4) ? 2 : 3 + RDW;
            ref_mem[a[7:2]] = exp_wdata;
        end

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        got = bus.req_ready;
        check("accept_seen", 32'(got), 32'h1);
        rdata_obs = 32'h0;
        wdata_obs = 32'h0;
        if (!got) begin
            bus.req_valid = 1'b0;
            return;
        end

        rd_cnt = 0; wr_cnt = 0; rdy_cnt = 0; lat = 0; got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            check("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'h0);
            if (bus.mem_read) begin
                rd_cnt++;
                check("rd_addr", bus.mem_addr, {a[31:2], 2'b00});
            end
            if (bus.mem_write) begin
                wr_cnt++;
                wdata_obs = bus.mem_wdata;
                check("wr_addr", bus.mem_addr, {a[31:2], 2'b00});
            end else begin
                check("wdata_idle", bus.mem_wdata, 32'h0);
            end
            if (bus.req_ready) rdy_cnt++;
            if (bus.resp_valid) begin
                got       = 1'b1;
                lat       = i;
                rdata_obs = bus.resp_rdata;
                check("resp_err", 32'(bus.resp_err), 32'(err));
                check("resp_rdata", bus.resp_rdata, exp_rdata);
            end
        end
        bus.req_valid = 1'b0;
        check("resp_seen", 32'(got), 32'h1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rd_cycles", 32'(rd_cnt), 32'(exp_rd));
        check("wr_cycles", 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr != 0) check("mem_wdata", wdata_obs, exp_wdata);
        check("busy_ready", 32'(rdy_cnt), 32'h0);
        @(negedge clk);
        check("resp_pulse", 32'(bus.resp_valid), 32'h0);
        check("ready_after", 32'(bus.req_ready), 32'h1);
        check("rdata_hold", bus.resp_rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] ro, wo;
        int k;
        rst_n            = 1'b0;
        pre_we           = 1'b0;
        pre_idx          = 6'h0;
        pre_data         = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // Reset state, memory fill while held in reset
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(1,  32'h0A0B_0C0D);
        preload(8,  32'h1122_3344);
        preload(12, 32'h80FF_7F01);
        preload(16, 32'h5566_7788);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_at_release", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        check("ready_after_release", 32'(bus.req_ready), 32'h1);

        // Word store then word load at 0x10
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, ro, wo);
        check("sw_wdata", wo, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, ro, wo);
        check("lw_0x10", ro, 32'hDEAD_BEEF);

        // Byte store into the middle of a word
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 1'b0, ro, wo);
        check("sb_merge", wo, 32'h11AA_3344);

        // Sign/zero-extended sub-word loads
        do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0, ro, wo);
        check("lb_0x31", ro, 32'hFFFF_FFFF);
        do_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 1'b0, ro, wo);
        check("lbu_0x31", ro, 32'h0000_00FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0, ro, wo);
        check("lh_0x30", ro, 32'hFFFF_80FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, ro, wo);
        check("lhu_0x32", ro, 32'h0000_7F01);

        // Misaligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0, ro, wo);
`ifdef LSU_ERR_EN
        check("lw_misaligned", ro, 32'h0);
`else
        check("lw_misaligned", ro, 32'h0A0B_0C0D);
`endif

        // req_valid held high through a long read
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, ro, wo);
        check("lw_hold", ro, 32'h5566_7788);

        // Reset in the middle of a word store: write must be abandoned
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'hCAFE_F00D;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_accept", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        check("mid_write_high", 32'(bus.mem_write), 32'h1);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_ready_release", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        check("mid_ready_after", 32'(bus.req_ready), 32'h1);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, ro, wo);
        check("aborted_store", ro, 32'h5566_7788);

        // Random traffic against the model
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)), ro, wo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
